// File: rtl/multiplier_rr_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_rr_seq
// Brief    : Sequential split-operand multiplier. One shifted partial product
//            is accumulated per cycle. Approximate mode skips the AL*BL term.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_rr_seq #(
    parameter int W     = 8,
    parameter int SPLIT = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       A,
    input  logic [W-1:0]       B,
    input  logic               approx,
    output logic [2*W-1:0]     P,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PP_HH = 3'd1,
        S_PP_HL = 3'd2,
        S_PP_LH = 3'd3,
        S_PP_LL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_approx;
    logic [2*W-1:0]     r_acc;
    logic [CNT_W-1:0]   r_op_count;

    logic [W-1:0]       w_ah;
    logic [W-1:0]       w_al;
    logic [W-1:0]       w_bh;
    logic [W-1:0]       w_bl;
    logic [W-1:0]       w_x;
    logic [W-1:0]       w_y;
    logic [2*W-1:0]     w_prod;
    logic [2*W-1:0]     w_pp;
    logic               w_accept;
    logic               w_handshake;
    logic               w_in_pp;

    // Halves are zero-extended to W so a single W x W multiplier serves all terms.
    assign w_ah = {{SPLIT{1'b0}}, r_a[W-1:SPLIT]};
    assign w_al = {{(W-SPLIT){1'b0}}, r_a[SPLIT-1:0]};
    assign w_bh = {{SPLIT{1'b0}}, r_b[W-1:SPLIT]};
    assign w_bl = {{(W-SPLIT){1'b0}}, r_b[SPLIT-1:0]};

    always_comb begin
        w_x = '0;
        w_y = '0;
        case (r_state)
            S_PP_HH: begin w_x = w_ah; w_y = w_bh; end
            S_PP_HL: begin w_x = w_ah; w_y = w_bl; end
            S_PP_LH: begin w_x = w_al; w_y = w_bh; end
            S_PP_LL: begin w_x = w_al; w_y = w_bl; end
            default: begin w_x = '0;   w_y = '0;   end
        endcase
    end

    assign w_prod = {{W{1'b0}}, w_x} * {{W{1'b0}}, w_y};

    always_comb begin
        w_pp = w_prod;
        case (r_state)
            S_PP_HH:          w_pp = w_prod << (2 * SPLIT);
            S_PP_HL, S_PP_LH: w_pp = w_prod << SPLIT;
            default:          w_pp = w_prod;
        endcase
    end

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_handshake = out_ready && (r_state == S_DONE);
    assign w_in_pp     = (r_state == S_PP_HH) || (r_state == S_PP_HL) ||
                         (r_state == S_PP_LH) || (r_state == S_PP_LL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_PP_HH;
            S_PP_HH: w_next = S_PP_HL;
            S_PP_HL: w_next = S_PP_LH;
            S_PP_LH: w_next = r_approx ? S_DONE : S_PP_LL;
            S_PP_LL: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_approx   <= 1'b0;
            r_acc      <= '0;
            r_op_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a      <= A;
                r_b      <= B;
                r_approx <= approx;
                r_acc    <= '0;
            end else if (w_in_pp) begin
                r_acc <= r_acc + w_pp;
            end
            if (w_handshake) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign P         = r_acc;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_rr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_rr_seq
// Brief    : Scoreboard bench for multiplier_rr_seq (W=8/SPLIT=2 and
//            W=16/SPLIT=5/CNT_W=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_rr_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, approx, out_valid, out_ready, busy;
    logic [7:0]  A, B;
    logic [15:0] P;
    logic [15:0] op_count;

    logic        in_valid2, in_ready2, approx2, out_valid2, out_ready2, busy2;
    logic [15:0] A2, B2;
    logic [31:0] P2;
    logic [1:0]  op_count2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done1  = 0;
    int n_done2  = 0;
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #5 clk = ~clk;

    multiplier_rr_seq #(.W(8), .SPLIT(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .approx(approx), .P(P), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .op_count(op_count)
    );

    multiplier_rr_seq #(.W(16), .SPLIT(5), .CNT_W(2)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A2), .B(B2), .approx(approx2), .P(P2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .op_count(op_count2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] model(input int s, input logic [31:0] a,
                                          input logic [31:0] b, input logic ap);
        logic [63:0] al, bl, p;
        al = 64'(a) & ((64'd1 << s) - 64'd1);
        bl = 64'(b) & ((64'd1 << s) - 64'd1);
        p  = 64'(a) * 64'(b);
        if (ap) p = p - al * bl;
        return p;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) check("unexpected_out", 64'(1), 64'(0));
            else check("P", 64'(P), q1.pop_front());
            n_done1++;
        end
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) check("unexpected_out2", 64'(1), 64'(0));
            else check("P2", 64'(P2), q2.pop_front());
            n_done2++;
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ap, input int hold);
        int lat;
        logic [63:0] exp;
        exp = model(2, 32'(a), 32'(b), ap);
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; approx = ap; out_ready = (hold == 0);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        q1.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); approx = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), ap ? 64'(4) : 64'(5));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_P", 64'(P), exp);
            @(posedge clk); #1;
            in_valid = ~in_valid; A = 8'($urandom); B = 8'($urandom);
            if (i == hold - 1) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("valid_drop", 64'(out_valid), 64'(0));
        check("idle_ready", 64'(in_ready), 64'(1));
        check("op_count", 64'(op_count), 64'(n_done1[15:0]));
    endtask

    task automatic run_op2(input logic [15:0] a, input logic [15:0] b, input logic ap);
        int lat;
        @(posedge clk); #1;
        in_valid2 = 1'b1; A2 = a; B2 = b; approx2 = ap;
        @(negedge clk);
        check("in_ready2", 64'(in_ready2), 64'(1));
        q2.push_back(model(5, 32'(a), 32'(b), ap));
        @(posedge clk); #1;
        in_valid2 = 1'b0; A2 = 16'($urandom); B2 = 16'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency2", 64'(lat), ap ? 64'(4) : 64'(5));
        @(negedge clk);
        check("op_count2", 64'(op_count2), 64'(n_done2[1:0]));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; A = '0; B = '0; approx = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; A2 = '0; B2 = '0; approx2 = 1'b0; out_ready2 = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_after", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_P", 64'(P), 64'(0));
        check("rst_op_count", 64'(op_count), 64'(0));

        check("model_ff", model(2, 32'd255, 32'd255, 1'b0), 64'd65025);
        run_op(8'd255, 8'd255, 1'b0, 0);
        run_op(8'd255, 8'd255, 1'b1, 0);
        run_op(8'hB6, 8'h2D, 1'b0, 0);
        run_op(8'hB6, 8'h2D, 1'b1, 0);
        run_op(8'hB6, 8'h2D, 1'b0, 3);
        run_op(8'h00, 8'hFF, 1'b0, 0);
        for (int k = 0; k < 8; k++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // Abort an exact operation while it sits in PP_HL.
        @(posedge clk); #1;
        in_valid = 1'b1; A = 8'hB6; B = 8'h2D; approx = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        q1.push_back(model(2, 32'hB6, 32'h2D, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", 64'(busy), 64'(1));
        check("pre_rst_count", 64'(op_count == 16'd0), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'(0));
        void'(q1.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        n_done1 = 0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_P", 64'(P), 64'(0));
        check("abort_op_count", 64'(op_count), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        run_op(8'hB6, 8'h2D, 1'b1, 0);
        run_op(8'hB6, 8'h2D, 1'b0, 1);

        run_op2(16'hFFFF, 16'hFFFF, 1'b0);
        run_op2(16'hFFFF, 16'hFFFF, 1'b1);
        run_op2(16'h1234, 16'hABCD, 1'b0);
        run_op2(16'($urandom), 16'($urandom), 1'b1);
        run_op2(16'($urandom), 16'($urandom), 1'b0);
        check("p16_exact_ref", model(5, 32'hFFFF, 32'hFFFF, 1'b0), 64'hFFFE0001);

        repeat (3) @(negedge clk);
        check("q1_empty", 64'(q1.size()), 64'(0));
        check("q2_empty", 64'(q2.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
